// File: rtl/regfile_multiport_pkg.sv
// rtl/regfile_multiport_pkg.sv - shared defaults for the multiport register file
package regfile_multiport_pkg;
   localparam int XLEN_DEFAULT  = 32;
   localparam int NREGS_DEFAULT = 32;
   localparam int AW            = $clog2(NREGS_DEFAULT);
endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one combinational read port with write bypass and zero-register mux
module regfile_read_port #(
   parameter int XLEN     = 32,
   parameter int AW       = 5,
   parameter int NWRITE   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic [AW-1:0]          rd_addr,
   input  logic [XLEN-1:0]        arr_data,
   input  logic                   arr_busy,
   input  logic [NWRITE-1:0]      wr_en,
   input  logic [NWRITE*AW-1:0]   wr_addr,
   input  logic [NWRITE*XLEN-1:0] wr_data,
   output logic [XLEN-1:0]        rd_data,
   output logic                   rd_busy
);
   always_comb begin
      rd_data = arr_data;
      rd_busy = arr_busy;
      // ascending scan so the highest matching write port is the one that sticks
      for (int j = 0; j < NWRITE; j++) begin
         if (wr_en[j] && (wr_addr[j*AW +: AW] == rd_addr)) begin
            rd_data = wr_data[j*XLEN +: XLEN];
            rd_busy = 1'b0;
         end
      end
      if ((ZERO_REG != 0) && (rd_addr == '0)) begin
         rd_data = '0;
         rd_busy = 1'b0;
      end
   end
endmodule

// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - NREAD/NWRITE register file with bypass and busy-bit scoreboard
module regfile_multiport
   import regfile_multiport_pkg::*;
#(
   parameter int XLEN     = XLEN_DEFAULT,
   parameter int NREGS    = NREGS_DEFAULT,
   parameter int NREAD    = 2,
   parameter int NWRITE   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NREAD*$clog2(NREGS)-1:0]    rd_addr,
   output logic [NREAD*XLEN-1:0]             rd_data,
   output logic [NREAD-1:0]                  rd_busy,
   input  logic [NWRITE-1:0]                 wr_en,
   input  logic [NWRITE*$clog2(NREGS)-1:0]   wr_addr,
   input  logic [NWRITE*XLEN-1:0]            wr_data,
   input  logic                              iss_valid,
   input  logic [$clog2(NREGS)-1:0]          iss_rd,
   output logic [NREGS-1:0]                  busy_vec
);
   localparam int ADDR_W = $clog2(NREGS);

   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] busy_next;

   assign busy_vec = busy;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      end else begin
         // later ports overwrite earlier ones on an address collision
         for (int j = 0; j < NWRITE; j++) begin
            if (wr_en[j] && !((ZERO_REG != 0) && (wr_addr[j*ADDR_W +: ADDR_W] == '0)))
               regs[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*XLEN +: XLEN];
         end
      end
   end

   always_comb begin
      busy_next = busy;
      for (int j = 0; j < NWRITE; j++) begin
         if (wr_en[j]) busy_next[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
      end
      // a new producer supersedes the one retiring this cycle
      if (iss_valid) busy_next[iss_rd] = 1'b1;
      if (ZERO_REG != 0) busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) busy <= '0;
      else       busy <= busy_next;
   end

   for (genvar i = 0; i < NREAD; i++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      assign addr = rd_addr[i*ADDR_W +: ADDR_W];

      regfile_read_port #(
         .XLEN     (XLEN),
         .AW       (ADDR_W),
         .NWRITE   (NWRITE),
         .ZERO_REG (ZERO_REG)
      ) u_port (
         .rd_addr  (addr),
         .arr_data (regs[addr]),
         .arr_busy (busy[addr]),
         .wr_en    (wr_en),
         .wr_addr  (wr_addr),
         .wr_data  (wr_data),
         .rd_data  (rd_data[i*XLEN +: XLEN]),
         .rd_busy  (rd_busy[i])
      );
   end
endmodule

// File: tb/tb_regfile_multiport.sv
// tb/tb_regfile_multiport.sv - directed self-checking bench for regfile_multiport
module tb_regfile_multiport;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [9:0]  a_rd_addr;
   logic [63:0] a_rd_data;
   logic [1:0]  a_rd_busy;
   logic [1:0]  a_wr_en;
   logic [9:0]  a_wr_addr;
   logic [63:0] a_wr_data;
   logic        a_iss_valid;
   logic [4:0]  a_iss_rd;
   logic [31:0] a_busy_vec;

   logic [11:0] b_rd_addr;
   logic [95:0] b_rd_data;
   logic [2:0]  b_rd_busy;
   logic [0:0]  b_wr_en;
   logic [3:0]  b_wr_addr;
   logic [31:0] b_wr_data;
   logic        b_iss_valid;
   logic [3:0]  b_iss_rd;
   logic [15:0] b_busy_vec;

   int n_cmp = 0;
   int n_fail = 0;

   regfile_multiport u_a (
      .clk(clk), .reset(reset),
      .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
      .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
      .iss_valid(a_iss_valid), .iss_rd(a_iss_rd), .busy_vec(a_busy_vec)
   );

   regfile_multiport #(.XLEN(32), .NREGS(16), .NREAD(3), .NWRITE(1), .ZERO_REG(0)) u_b (
      .clk(clk), .reset(reset),
      .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
      .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
      .iss_valid(b_iss_valid), .iss_rd(b_iss_rd), .busy_vec(b_busy_vec)
   );

   task automatic idle();
      a_wr_en = '0; a_wr_addr = '0; a_wr_data = '0;
      a_iss_valid = 1'b0; a_iss_rd = '0;
      b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0;
      b_iss_valid = 1'b0; b_iss_rd = '0;
   endtask

   task automatic test_reset();
      a_rd_addr = {5'd7, 5'd5};
      b_rd_addr = '0;
      idle();
      #1;
      n_cmp++; if (a_rd_data[31:0] !== 32'h0) begin n_fail++; $display("FAIL reset_init_data: got %h want %h", a_rd_data[31:0], 32'h0); end
      n_cmp++; if (a_busy_vec !== 32'h0) begin n_fail++; $display("FAIL reset_init_busy: got %h want %h", a_busy_vec, 32'h0); end
      n_cmp++; if (a_rd_busy !== 2'b00) begin n_fail++; $display("FAIL reset_init_rdbusy: got %b want %b", a_rd_busy, 2'b00); end
      @(negedge clk); reset = 1'b0;
      a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd5}; a_wr_data = {32'h0, 32'h1234};
      a_iss_valid = 1'b1; a_iss_rd = 5'd7;
      @(negedge clk); idle();
      #1;
      n_cmp++; if (a_rd_data[31:0] !== 32'h1234) begin n_fail++; $display("FAIL reset_pre_r5: got %h want %h", a_rd_data[31:0], 32'h1234); end
      n_cmp++; if (a_rd_busy[1] !== 1'b1) begin n_fail++; $display("FAIL reset_pre_r7busy: got %b want %b", a_rd_busy[1], 1'b1); end
      // assert mid-cycle with a write and issue pending; both must be discarded
      #2;
      a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd10}; a_wr_data = {32'h0, 32'hAAAA};
      a_iss_valid = 1'b1; a_iss_rd = 5'd8;
      reset = 1'b1;
      #1;
      n_cmp++; if (a_rd_data[31:0] !== 32'h0) begin n_fail++; $display("FAIL reset_async_r5: got %h want %h", a_rd_data[31:0], 32'h0); end
      n_cmp++; if (a_busy_vec !== 32'h0) begin n_fail++; $display("FAIL reset_async_busy: got %h want %h", a_busy_vec, 32'h0); end
      n_cmp++; if (a_rd_busy !== 2'b00) begin n_fail++; $display("FAIL reset_async_rdbusy: got %b want %b", a_rd_busy, 2'b00); end
      @(posedge clk); @(negedge clk);
      idle(); reset = 1'b0;
      a_rd_addr = {5'd8, 5'd10};
      #1;
      n_cmp++; if (a_rd_data[31:0] !== 32'h0) begin n_fail++; $display("FAIL reset_discard_wr: got %h want %h", a_rd_data[31:0], 32'h0); end
      n_cmp++; if (a_busy_vec !== 32'h0) begin n_fail++; $display("FAIL reset_discard_iss: got %h want %h", a_busy_vec, 32'h0); end
   endtask

   task automatic test_write_read();
      @(negedge clk);
      a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd3}; a_wr_data = {32'h0, 32'hDEADBEEF};
      a_rd_addr = {5'd0, 5'd0};
      @(negedge clk); idle();
      a_rd_addr = {5'd3, 5'd3};
      #1;
      n_cmp++; if (a_rd_data[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_rd_p0: got %h want %h", a_rd_data[31:0], 32'hDEADBEEF); end
      n_cmp++; if (a_rd_data[63:32] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_rd_p1: got %h want %h", a_rd_data[63:32], 32'hDEADBEEF); end
      @(negedge clk);
      a_wr_en = 2'b10; a_wr_addr = {5'd0, 5'd0}; a_wr_data = {32'hFFFFFFFF, 32'h0};
      a_rd_addr = {5'd0, 5'd0};
      #1;
      n_cmp++; if (a_rd_data[31:0] !== 32'h0) begin n_fail++; $display("FAIL r0_no_bypass: got %h want %h", a_rd_data[31:0], 32'h0); end
      @(negedge clk); idle();
      #1;
      n_cmp++; if (a_rd_data[63:32] !== 32'h0) begin n_fail++; $display("FAIL r0_hardwired: got %h want %h", a_rd_data[63:32], 32'h0); end
      // disabled write must not land
      @(negedge clk);
      a_wr_en = 2'b00; a_wr_addr = {5'd3, 5'd3}; a_wr_data = {32'h99, 32'h98};
      @(negedge clk); idle();
      a_rd_addr = {5'd0, 5'd3};
      #1;
      n_cmp++; if (a_rd_data[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_en_off: got %h want %h", a_rd_data[31:0], 32'hDEADBEEF); end
   endtask

   task automatic test_collision();
      @(negedge clk);
      a_wr_en = 2'b11; a_wr_addr = {5'd9, 5'd9}; a_wr_data = {32'h22, 32'h11};
      a_rd_addr = {5'd9, 5'd9};
      #1;
      n_cmp++; if (a_rd_data[31:0] !== 32'h22) begin n_fail++; $display("FAIL bypass_prio: got %h want %h", a_rd_data[31:0], 32'h22); end
      @(negedge clk); idle();
      #1;
      n_cmp++; if (a_rd_data[63:32] !== 32'h22) begin n_fail++; $display("FAIL collision_store: got %h want %h", a_rd_data[63:32], 32'h22); end
   endtask

   task automatic test_scoreboard();
      @(negedge clk);
      a_iss_valid = 1'b1; a_iss_rd = 5'd4;
      a_rd_addr = {5'd0, 5'd4};
      #1;
      n_cmp++; if (a_rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL iss_not_visible: got %b want %b", a_rd_busy[0], 1'b0); end
      @(negedge clk); idle();
      #1;
      n_cmp++; if (a_rd_busy[0] !== 1'b1) begin n_fail++; $display("FAIL hazard_busy: got %b want %b", a_rd_busy[0], 1'b1); end
      n_cmp++; if (a_busy_vec !== 32'h10) begin n_fail++; $display("FAIL hazard_vec: got %h want %h", a_busy_vec, 32'h10); end
      @(negedge clk);
      a_wr_en = 2'b10; a_wr_addr = {5'd4, 5'd0}; a_wr_data = {32'h55, 32'h0};
      #1;
      n_cmp++; if (a_rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL bypass_busy: got %b want %b", a_rd_busy[0], 1'b0); end
      n_cmp++; if (a_rd_data[31:0] !== 32'h55) begin n_fail++; $display("FAIL bypass_data: got %h want %h", a_rd_data[31:0], 32'h55); end
      @(negedge clk); idle();
      #1;
      n_cmp++; if (a_busy_vec[4] !== 1'b0) begin n_fail++; $display("FAIL busy_clear: got %b want %b", a_busy_vec[4], 1'b0); end
   endtask

   task automatic test_race();
      @(negedge clk);
      a_iss_valid = 1'b1; a_iss_rd = 5'd6;
      a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd6}; a_wr_data = {32'h0, 32'h66};
      @(negedge clk); idle();
      a_rd_addr = {5'd0, 5'd6};
      #1;
      n_cmp++; if (a_busy_vec[6] !== 1'b1) begin n_fail++; $display("FAIL race_set_wins: got %b want %b", a_busy_vec[6], 1'b1); end
      n_cmp++; if (a_rd_data[31:0] !== 32'h66) begin n_fail++; $display("FAIL race_data: got %h want %h", a_rd_data[31:0], 32'h66); end
      n_cmp++; if (a_rd_busy[0] !== 1'b1) begin n_fail++; $display("FAIL race_rdbusy: got %b want %b", a_rd_busy[0], 1'b1); end
      @(negedge clk);
      a_iss_valid = 1'b1; a_iss_rd = 5'd6;
      @(negedge clk);
      a_iss_valid = 1'b1; a_iss_rd = 5'd0;
      @(negedge clk); idle();
      #1;
      n_cmp++; if (a_busy_vec !== 32'h40) begin n_fail++; $display("FAIL reissue_r0: got %h want %h", a_busy_vec, 32'h40); end
   endtask

   task automatic test_sweep();
      @(negedge clk);
      b_wr_en = 1'b1; b_wr_addr = 4'd0; b_wr_data = 32'h7;
      @(negedge clk);
      b_wr_addr = 4'd1; b_wr_data = 32'hA;
      @(negedge clk);
      b_wr_addr = 4'd15; b_wr_data = 32'hC;
      @(negedge clk); idle();
      b_rd_addr = {4'd15, 4'd1, 4'd0};
      #1;
      n_cmp++; if (b_rd_data[31:0] !== 32'h7) begin n_fail++; $display("FAIL sweep_r0: got %h want %h", b_rd_data[31:0], 32'h7); end
      n_cmp++; if (b_rd_data[63:32] !== 32'hA) begin n_fail++; $display("FAIL sweep_r1: got %h want %h", b_rd_data[63:32], 32'hA); end
      n_cmp++; if (b_rd_data[95:64] !== 32'hC) begin n_fail++; $display("FAIL sweep_r15: got %h want %h", b_rd_data[95:64], 32'hC); end
      @(negedge clk);
      b_iss_valid = 1'b1; b_iss_rd = 4'd0;
      @(negedge clk); idle();
      #1;
      n_cmp++; if (b_busy_vec !== 16'h0001) begin n_fail++; $display("FAIL sweep_r0_busy: got %h want %h", b_busy_vec, 16'h0001); end
      n_cmp++; if (b_rd_busy !== 3'b001) begin n_fail++; $display("FAIL sweep_rdbusy: got %b want %b", b_rd_busy, 3'b001); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_collision();
      test_scoreboard();
      test_race();
      test_sweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
